id_decode_stage: RTL
====================

# id_decode_stage

Registered MIPS instruction-decode pipeline stage sitting between the fetch stage and execute. It accepts one 32-bit instruction plus its PC per valid/ready handshake and decodes fields, extended immediates, branch/jump targets and control flags. Results appear in an output register one cycle later. The stage also adds a flush path, illegal-opcode flagging, and optional load-use interlock with a saturating stall counter.

## Interface
Parameters:
- PC_W, 32, PC/target width; legal range 28..32.
- LINK_REG, 31, destination register written by JAL.
- STALL_CNT_W, 16, stall counter width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  fetch has an instruction.
- o_ready  out  1  stage accepts this cycle.
- i_instr  in  32  instruction word.
- i_pc  in  PC_W  PC of i_instr.
- i_flush  in  1  kill the held instruction and the one being offered.
- o_valid  out  1  output register holds a decoded instruction.
- i_ready  in  1  execute accepts this cycle.
- o_pc  out  PC_W  registered PC.
- o_funct  out  6  R-type funct; for I-arith/load/store {3'b0, opcode[2:0]}; 0 for jumps and branches.
- o_rs, o_rt  out  5 each  source registers; 0 when unused.
- o_dst  out  5  destination: rd (R-type, JALR), rt (I-arith, loads), LINK_REG (JAL), else 0.
- o_sa  out  5  shift amount.
- o_imm_ext  out  32  extended immediate.
- o_target  out  PC_W  branch/jump target; 0 for JR/JALR.
- o_pc_modify, o_link, o_cmp, o_equal, o_imm_sel, o_mem_op, o_mem_store, o_unsign, o_reg_write, o_illegal  out  1 each  control flags.
- o_addr_type  out  2  00 register, 01 pseudo-direct, 10 PC-relative.
- o_mem_size  out  2  00 byte, 01 half, 11 word.
- o_stall_cnt  out  STALL_CNT_W  number of load-use bubbles inserted.

## Operation
- Accept when i_valid && o_ready; the output register loads the decode and o_valid is set to 1.
- Decoded opcodes:
  - R-type: JR is 001000 and JALR is 001001 (register address); all other funct values are ALU operations.
  - J is 000010; JAL is 000011.
  - BEQ is 000100; BNE is 000101.
  - Arith-imm is 001000–001111.
  - Loads are 100000, 100001, 100011, 100100, 100101, 100111.
  - Stores are 101000, 101001, 101011.
- Every other opcode: o_illegal=1, o_reg_write=0, all other flags 0; o_valid is still asserted.
- Immediate extension:
  - ANDI/ORI/XORI zero-extend.
  - LUI gives {imm,16'h0}.
  - Arith-imm, load, store and branch sign-extend.
- Targets:
  - Branch target is (pc+4) + (sext(imm)<<2), modulo 2^PC_W.
  - J/JAL target is {(pc+4)[PC_W-1:28], offset26, 2'b00}.
- Loads and stores:
  - o_mem_size is opcode[1:0].
  - o_unsign is opcode[2] for loads and 0 for stores.
- o_reg_write=1 for R-type except JR, for JALR, JAL, arith-imm and loads.
- A destination of 0 never forces o_reg_write to 0.
- Load-use hazard:
  - Condition: o_valid && o_mem_op && !o_mem_store && o_dst!=0 && the incoming instruction reads o_dst as rs or rt.
  - Response: o_ready=0; when i_ready is high the output register is loaded with a bubble (o_valid=0) and o_stall_cnt increments.
  - o_stall_cnt saturates at all-ones.
- Flush:
  - o_valid is cleared next edge; the offered instruction is discarded and not retained.
  - o_ready is unaffected; the discarding accept is still counted as a handshake by fetch.
  - Flush has priority over accept and stall.
  - A flush in a stall cycle does not increment o_stall_cnt.

## Timing
- Latency: 1 cycle from handshake to o_valid.
- Throughput: 1 instruction per cycle without hazards.
- o_ready = (!o_valid || i_ready) && !hazard; it is combinational from i_ready.
- Hold: while o_valid && !i_ready, all outputs are held stable.
- Reset: o_valid=0, all decoded outputs 0, o_stall_cnt=0; o_ready=1 after reset deasserts.
- Reset mid-operation: the held instruction is dropped immediately (asynchronous).
- Hazard lasts exactly one cycle: after the bubble the load has left, so the dependent instruction is accepted on the next cycle.

## Configuration
- DECODE_HAZARD_EN defined: load-use interlock and stall counter are active.
- DECODE_HAZARD_EN not defined: hazard is constant 0, so o_ready = !o_valid || i_ready; o_stall_cnt is tied to 0 and the port is kept.

## Test plan
- ADDI 0x2001FFFF then ORI 0x3402FFFF, i_ready=1 -> o_imm_ext 0xFFFFFFFF then 0x0000FFFF; o_dst 1 then 2; o_reg_write=1, o_imm_sel=1.
- LW 0x8C030000 followed by ADD 0x00632020, i_ready=1 -> one bubble cycle (o_valid=0), o_ready low for 1 cycle, ADD emitted the next cycle, o_stall_cnt=1; with the macro undefined, no bubble and count stays 0.
- JAL 0x0C000010 at pc 0x00400000 -> o_target 0x00000040, o_dst 31, o_link=1, o_addr_type 01.
- BEQ 0x1000FFFF at pc 0x00000100 -> o_target 0x00000100, o_cmp=1, o_equal=1, o_addr_type 10.
- i_ready=0 for 3 cycles with LB 0x80050004 held -> outputs stable, o_ready=0, o_mem_size 00, o_unsign=0; then i_flush=1 -> o_valid=0 next cycle.
- Opcode 0xFC000000 -> o_illegal=1, o_valid=1, o_reg_write=0; assert i_rst_n=0 mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/id_decode_stage_if.sv
// Fetch/decode/execute handshake bundle for id_decode_stage.
// slave: the decode stage; master: the fetch+execute side driving it.
interface id_decode_stage_if #(
  parameter int PC_W        = 32,
  parameter int STALL_CNT_W = 16
);
  logic                   i_valid;
  logic                   o_ready;
  logic [31:0]            i_instr;
  logic [PC_W-1:0]        i_pc;
  logic                   i_flush;
  logic                   o_valid;
  logic                   i_ready;
  logic [PC_W-1:0]        o_pc;
  logic [5:0]             o_funct;
  logic [4:0]             o_rs;
  logic [4:0]             o_rt;
  logic [4:0]             o_dst;
  logic [4:0]             o_sa;
  logic [31:0]            o_imm_ext;
  logic [PC_W-1:0]        o_target;
  logic                   o_pc_modify;
  logic                   o_link;
  logic                   o_cmp;
  logic                   o_equal;
  logic                   o_imm_sel;
  logic                   o_mem_op;
  logic                   o_mem_store;
  logic                   o_unsign;
  logic                   o_reg_write;
  logic                   o_illegal;
  logic [1:0]             o_addr_type;
  logic [1:0]             o_mem_size;
  logic [STALL_CNT_W-1:0] o_stall_cnt;

  modport slave (
    input  i_valid, i_instr, i_pc, i_flush, i_ready,
    output o_ready, o_valid, o_pc, o_funct, o_rs, o_rt,
    output o_dst, o_sa, o_imm_ext, o_target,
    output o_pc_modify, o_link, o_cmp, o_equal, o_imm_sel,
    output o_mem_op, o_mem_store, o_unsign, o_reg_write,
    output o_illegal, o_addr_type, o_mem_size, o_stall_cnt
  );

  modport master (
    output i_valid, i_instr, i_pc, i_flush, i_ready,
    input  o_ready, o_valid, o_pc, o_funct, o_rs, o_rt,
    input  o_dst, o_sa, o_imm_ext, o_target,
    input  o_pc_modify, o_link, o_cmp, o_equal, o_imm_sel,
    input  o_mem_op, o_mem_store, o_unsign, o_reg_write,
    input  o_illegal, o_addr_type, o_mem_size, o_stall_cnt
  );
endinterface

// File: rtl/id_decode_stage.sv
// Registered MIPS decode stage: fields, immediates, targets, flags.
// Ports: i_clk, i_rst_n, bus (slave). DECODE_HAZARD_EN adds load-use stall.
module id_decode_stage #(
  parameter int PC_W        = 32,
  parameter int LINK_REG    = 31,
  parameter int STALL_CNT_W = 16
) (
  input logic         i_clk,
  input logic         i_rst_n,
  id_decode_stage_if.slave bus
);
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [5:0]      funct;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      dst;
    logic [4:0]      sa;
    logic [31:0]     imm;
    logic [PC_W-1:0] target;
    logic            pc_modify;
    logic            link;
    logic            cmp;
    logic            equal;
    logic            imm_sel;
    logic            mem_op;
    logic            mem_store;
    logic            unsign;
    logic            reg_write;
    logic            illegal;
    logic [1:0]      addr_type;
    logic [1:0]      mem_size;
  } dec_t;

  dec_t d, q;
  logic valid;
  logic hazard;
  logic accept;

  logic [31:0]     ins;
  logic [5:0]      op;
  logic [15:0]     imm;
  logic [31:0]     sext;
  logic [31:0]     boff;
  logic [PC_W-1:0] pc4;
  logic [31:0]     pc4_w;
  logic [31:0]     jt;
  logic is_r, is_j, is_jal, is_br;
  logic is_ari, is_ld, is_st;

  assign ins   = bus.i_instr;
  assign op    = ins[31:26];
  assign imm   = ins[15:0];
  assign sext  = {{16{imm[15]}}, imm};
  assign boff  = {sext[29:0], 2'b00};
  assign pc4   = bus.i_pc + PC_W'(4);
  assign pc4_w = 32'(pc4);
  // upper PC bits of pc+4 splice onto the 26-bit word offset
  assign jt    = {pc4_w[31:28], ins[25:0], 2'b00};

  assign is_r   = op == 6'b000000;
  assign is_j   = op == 6'b000010;
  assign is_jal = op == 6'b000011;
  assign is_br  = op[5:1] == 5'b00010;
  assign is_ari = op[5:3] == 3'b001;
  assign is_ld  = op[5:3] == 3'b100 && op[1:0] != 2'b10;
  assign is_st  = op[5:2] == 4'b1010 && op[1:0] != 2'b10;

  always_comb begin
    d    = '0;
    d.pc = bus.i_pc;
    unique case (1'b1)
      is_r: begin
        d.rs = ins[25:21];
        if (ins[5:1] == 5'b00100) begin
          d.pc_modify = 1'b1;
          d.link      = ins[0];
          d.reg_write = ins[0];
          d.dst       = ins[0] ? ins[15:11] : 5'd0;
        end else begin
          d.funct     = ins[5:0];
          d.rt        = ins[20:16];
          d.dst       = ins[15:11];
          d.sa        = ins[10:6];
          d.reg_write = 1'b1;
        end
      end
      is_j, is_jal: begin
        d.target    = jt[PC_W-1:0];
        d.pc_modify = 1'b1;
        d.addr_type = 2'b01;
        d.link      = is_jal;
        d.reg_write = is_jal;
        d.dst       = is_jal ? 5'(LINK_REG) : 5'd0;
      end
      is_br: begin
        d.rs        = ins[25:21];
        d.rt        = ins[20:16];
        d.imm       = sext;
        d.target    = pc4 + boff[PC_W-1:0];
        d.pc_modify = 1'b1;
        d.cmp       = 1'b1;
        d.equal     = ~op[0];
        d.addr_type = 2'b10;
      end
      is_ari: begin
        d.funct     = {3'b000, op[2:0]};
        d.rs        = ins[25:21];
        d.dst       = ins[20:16];
        d.imm_sel   = 1'b1;
        d.reg_write = 1'b1;
        unique case (op[2:0])
          3'b100, 3'b101, 3'b110: d.imm = {16'h0, imm};
          3'b111:                 d.imm = {imm, 16'h0};
          default:                d.imm = sext;
        endcase
      end
      is_ld, is_st: begin
        d.funct     = {3'b000, op[2:0]};
        d.rs        = ins[25:21];
        d.rt        = is_st ? ins[20:16] : 5'd0;
        d.dst       = is_ld ? ins[20:16] : 5'd0;
        d.imm       = sext;
        d.imm_sel   = 1'b1;
        d.mem_op    = 1'b1;
        d.mem_store = is_st;
        d.mem_size  = op[1:0];
        d.unsign    = is_ld & op[2];
        d.reg_write = is_ld;
      end
      default: d.illegal = 1'b1;
    endcase
  end

`ifdef DECODE_HAZARD_EN
  logic [STALL_CNT_W-1:0] stall_cnt;

  assign hazard = bus.i_valid && valid && q.mem_op &&
                  !q.mem_store && q.dst != 5'd0 &&
                  (d.rs == q.dst || d.rt == q.dst);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      stall_cnt <= '0;
    else if (!bus.i_flush && hazard && bus.i_ready &&
             stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign bus.o_stall_cnt = stall_cnt;
`else
  assign hazard          = 1'b0;
  assign bus.o_stall_cnt = '0;
`endif

  assign bus.o_ready = (!valid || bus.i_ready) && !hazard;
  assign accept      = bus.i_valid && bus.o_ready;

  // a stalled cycle with i_ready simply drains to a bubble
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (bus.i_flush) begin
      valid <= 1'b0;
    end else if (accept) begin
      valid <= 1'b1;
      q     <= d;
    end else if (bus.i_ready) begin
      valid <= 1'b0;
    end
  end

  assign bus.o_valid     = valid;
  assign bus.o_pc        = q.pc;
  assign bus.o_funct     = q.funct;
  assign bus.o_rs        = q.rs;
  assign bus.o_rt        = q.rt;
  assign bus.o_dst       = q.dst;
  assign bus.o_sa        = q.sa;
  assign bus.o_imm_ext   = q.imm;
  assign bus.o_target    = q.target;
  assign bus.o_pc_modify = q.pc_modify;
  assign bus.o_link      = q.link;
  assign bus.o_cmp       = q.cmp;
  assign bus.o_equal     = q.equal;
  assign bus.o_imm_sel   = q.imm_sel;
  assign bus.o_mem_op    = q.mem_op;
  assign bus.o_mem_store = q.mem_store;
  assign bus.o_unsign    = q.unsign;
  assign bus.o_reg_write = q.reg_write;
  assign bus.o_illegal   = q.illegal;
  assign bus.o_addr_type = q.addr_type;
  assign bus.o_mem_size  = q.mem_size;
endmodule
